// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
//
// Shares one combinational ALU between two requesters. One operation is
// accepted at a time over a valid/ready handshake. The operands and control
// code are registered onto the ALU inputs, and the ALU outputs are captured one
// cycle later. The response is then held until the owning requester takes it.
// Opcodes the ALU does not implement are never issued. They complete with
// resp_err set and a zero result.
//
// Parameters
//   WIDTH : operand/result width (must match the ALU)
//   FAIR  : 1 = round-robin between requesters, 0 = requester 0 always wins
//
// Ports
//   clk, reset              : clock (rising edge), async active-high reset
//   req_valid / req_ready   : per-requester request handshake (bit i = req i)
//   req{0,1}_a/_b/_op       : operands and ALU control code per requester
//   resp_valid / resp_ready : per-requester response handshake
//   resp_result/_zero/_err  : response payload shared by both requesters
//   alu_src1/_src2/_cont    : registered ALU inputs
//   alu_result, alu_zero    : ALU outputs (combinational from alu_* inputs)
// -----------------------------------------------------------------------------
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [2:0]       alu_cont,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_rr;
    logic              r_owner;
    logic              r_ill;
    logic [WIDTH-1:0]  r_src1;
    logic [WIDTH-1:0]  r_src2;
    logic [2:0]        r_cont;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_err;

    logic              w_grant;
    logic              w_accept;
    logic              w_resp_done;
    logic [2:0]        w_op;
    logic              w_op_ill;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;

    // Codes 100/101/110 have no ALU function behind them.
    function automatic logic op_illegal(input logic [2:0] op);
        logic ill;
        case (op)
            3'b100, 3'b101, 3'b110: ill = 1'b1;
            default:                ill = 1'b0;
        endcase
        return ill;
    endfunction

    // Winner selection. With both requesting, the rr pointer decides when
    // fair; otherwise requester 0 has fixed priority. A lone request wins.
    always_comb begin
        w_grant = 1'b0;
        if (req_valid == 2'b11) begin
            w_grant = FAIR ? r_rr : 1'b0;
        end else begin
            w_grant = req_valid[1];
        end
    end

    assign w_accept    = (r_state == S_IDLE) && (req_valid != 2'b00);
    assign w_resp_done = (r_state == S_RESP) && resp_ready[r_owner];

    assign w_op     = w_grant ? req1_op : req0_op;
    assign w_a      = w_grant ? req1_a  : req0_a;
    assign w_b      = w_grant ? req1_b  : req0_b;
    assign w_op_ill = op_illegal(w_op);

    assign req_ready  = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign resp_valid = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

    assign resp_result = r_result;
    assign resp_zero   = r_zero;
    assign resp_err    = r_err;
    assign alu_src1    = r_src1;
    assign alu_src2    = r_src2;
    assign alu_cont    = r_cont;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_next = S_EXEC;
            S_EXEC:                   w_next = S_RESP;
            S_RESP:  if (w_resp_done) w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    // Accept edge: capture owner and ALU inputs. Exec edge: capture ALU
    // outputs. Response completion: move the round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr     <= 1'b0;
            r_owner  <= 1'b0;
            r_ill    <= 1'b0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_cont   <= 3'b000;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant;
                r_src1  <= w_a;
                r_src2  <= w_b;
                // An illegal code is replaced by a harmless AND so the ALU
                // never sees an undefined control value.
                r_cont  <= w_op_ill ? 3'b000 : w_op;
                r_ill   <= w_op_ill;
            end
            if (r_state == S_EXEC) begin
                r_result <= r_ill ? '0 : alu_result;
                r_zero   <= r_ill ? 1'b0 : alu_zero;
                r_err    <= r_ill;
            end
            if (w_resp_done && FAIR) begin
                r_rr <= ~r_owner;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
//
// Bench for alu_share_arb. It holds two instances that share all inputs: one
// with FAIR=1 and one with FAIR=0. Each instance has its own ALU model driving
// alu_result/alu_zero. The bench applies a table of single operations, then
// hand-written backpressure, reset and contention sequences. It finishes with
// random traffic that is checked against a transaction-level reference.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] req0_a, req1_a, req0_b, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [1:0]  resp_ready;

    logic [1:0]  req_ready, resp_valid;
    logic [31:0] resp_result, alu_src1, alu_src2, alu_result;
    logic        resp_zero, resp_err, alu_zero;
    logic [2:0]  alu_cont;

    logic [1:0]  req_ready_f0, resp_valid_f0;
    logic [31:0] resp_result_f0, alu_src1_f0, alu_src2_f0, alu_result_f0;
    logic        resp_zero_f0, resp_err_f0, alu_zero_f0;
    logic [2:0]  alu_cont_f0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Environment ALU: and, or, add, sub, unsigned set-less-than.
    function automatic logic [31:0] alu_env(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b111:  return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result    = alu_env(alu_src1, alu_src2, alu_cont);
    assign alu_zero      = (alu_result == 32'd0);
    assign alu_result_f0 = alu_env(alu_src1_f0, alu_src2_f0, alu_cont_f0);
    assign alu_zero_f0   = (alu_result_f0 == 32'd0);

    alu_share_arb #(.WIDTH(32), .FAIR(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_result(resp_result), .resp_zero(resp_zero),
        .resp_err(resp_err), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_cont(alu_cont), .alu_result(alu_result), .alu_zero(alu_zero)
    );

    alu_share_arb #(.WIDTH(32), .FAIR(1'b0)) dut_f0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_f0),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op), .resp_valid(resp_valid_f0),
        .resp_ready(resp_ready), .resp_result(resp_result_f0), .resp_zero(resp_zero_f0),
        .resp_err(resp_err_f0), .alu_src1(alu_src1_f0), .alu_src2(alu_src2_f0),
        .alu_cont(alu_cont_f0), .alu_result(alu_result_f0), .alu_zero(alu_zero_f0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference for one operation: what the requester must receive back.
    function automatic void ref_op(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, output logic [31:0] r,
                                   output logic z, output logic e);
        e = 1'b0;
        r = 32'd0;
        if (op == 3'd0)      r = a & b;
        else if (op == 3'd1) r = a | b;
        else if (op == 3'd2) r = a + b;
        else if (op == 3'd3) r = a - b;
        else if (op == 3'd7) r = (a < b) ? 32'd1 : 32'd0;
        else                 e = 1'b1;
        z = !e && (r == 32'd0);
    endfunction

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        if (idx == 0) begin req0_a = a; req0_b = b; req0_op = op; end
        else          begin req1_a = a; req1_b = b; req1_op = op; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One operation from a single requester with the response taken at once.
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] er, input logic ez,
                          input logic ee);
        logic [1:0] m;
        m = (idx == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        set_req(idx, a, b, op);
        req_valid = m;
        #1;
        chk("op_req_ready", 32'(req_ready), 32'(m));
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("op_exec_resp_valid", 32'(resp_valid), 32'd0);
        chk("op_exec_alu_cont", 32'(alu_cont), ee ? 32'd0 : 32'(op));
        chk("op_exec_alu_src1", alu_src1, a);
        @(negedge clk);
        #1;
        chk("op_resp_valid", 32'(resp_valid), 32'(m));
        chk("op_resp_result", resp_result, er);
        chk("op_resp_zero", 32'(resp_zero), 32'(ez));
        chk("op_resp_err", 32'(resp_err), 32'(ee));
        chk("op_f0_resp_result", resp_result_f0, er);
        resp_ready = m;
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        chk("op_done_resp_valid", 32'(resp_valid), 32'd0);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        z;
        logic        e;
    } vec_t;

    vec_t tbl[12];

    // Random-phase state
    logic [1:0]  pend;
    logic [31:0] pa[2];
    logic [31:0] pb[2];
    logic [2:0]  pop[2];

    function automatic logic [31:0] rnd_operand();
        return ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : 32'($urandom);
    endfunction

    task automatic maybe_new();
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && ($urandom_range(2) != 0)) begin
                pend[i] = 1'b1;
                pa[i]   = rnd_operand();
                pb[i]   = rnd_operand();
                pop[i]  = 3'($urandom_range(7));
            end
        end
        req_valid = pend;
        set_req(0, pa[0], pb[0], pop[0]);
        set_req(1, pa[1], pb[1], pop[1]);
    endtask

    initial begin
        logic        w, rr_m, ez, ee;
        logic [1:0]  own, other, exp_rdy;
        logic [31:0] er;
        int          bp;
        int          gq[$];
        int          gq0[$];

        tbl[0]  = '{0, 32'd5,          32'd7,          3'b010, 32'd12,         1'b0, 1'b0};
        tbl[1]  = '{0, 32'd9,          32'd9,          3'b011, 32'd0,          1'b1, 1'b0};
        tbl[2]  = '{1, 32'd3,          32'd4,          3'b101, 32'd0,          1'b0, 1'b1};
        tbl[3]  = '{1, 32'h0000_FF00,  32'h0000_0FF0,  3'b000, 32'h0000_0F00,  1'b0, 1'b0};
        tbl[4]  = '{0, 32'h0000_00F0,  32'h0000_000F,  3'b001, 32'h0000_00FF,  1'b0, 1'b0};
        tbl[5]  = '{1, 32'd1,          32'd2,          3'b111, 32'd1,          1'b0, 1'b0};
        tbl[6]  = '{0, 32'd2,          32'd1,          3'b111, 32'd0,          1'b1, 1'b0};
        tbl[7]  = '{0, 32'd8,          32'd8,          3'b100, 32'd0,          1'b0, 1'b1};
        tbl[8]  = '{1, 32'd0,          32'd0,          3'b110, 32'd0,          1'b0, 1'b1};
        tbl[9]  = '{0, 32'hFFFF_FFFF,  32'd1,          3'b010, 32'd0,          1'b1, 1'b0};
        tbl[10] = '{1, 32'd0,          32'd1,          3'b011, 32'hFFFF_FFFF,  1'b0, 1'b0};
        tbl[11] = '{0, 32'hFFFF_FFFF,  32'd1,          3'b111, 32'd0,          1'b1, 1'b0};

        reset      = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        set_req(0, 32'd0, 32'd0, 3'd0);
        set_req(1, 32'd0, 32'd0, 3'd0);

        // Reset state
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_alu_src1", alu_src1, 32'd0);
        chk("rst_alu_cont", 32'(alu_cont), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table of single operations
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res, tbl[i].z, tbl[i].e);
        end

        // Backpressure: an OR held for 10 cycles with requester 1 waiting
        @(negedge clk);
        set_req(0, 32'h0000_00F0, 32'h0000_000F, 3'b001);
        req_valid = 2'b01;
        #1;
        chk("bp_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        set_req(1, 32'd3, 32'd4, 3'b010);
        req_valid = 2'b10;
        #1;
        chk("bp_exec_req_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            resp_ready = 2'b10;
            #1;
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_resp_result", resp_result, 32'h0000_00FF);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 2'b01;
        #1;
        chk("bp_return_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        chk("bp_idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("bp_next_req_ready", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("bp_next_resp_valid", 32'(resp_valid), 32'd2);
        chk("bp_next_resp_result", resp_result, 32'd7);
        resp_ready = 2'b10;
        @(negedge clk);
        resp_ready = 2'b00;

        // Reset between edges while in EXEC
        @(negedge clk);
        set_req(0, 32'd1, 32'd2, 3'b111);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("mid_exec_alu_cont", 32'(alu_cont), 32'd7);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_alu_cont", 32'(alu_cont), 32'd0);
        chk("mid_rst_alu_src2", alu_src2, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("mid_no_resp_valid", 32'(resp_valid), 32'd0);
        end
        run_op(0, 32'd1, 32'd2, 3'b111, 32'd1, 1'b0, 1'b0);

        // Reset between edges while in RESP
        @(negedge clk);
        set_req(1, 32'd10, 32'd3, 3'b011);
        req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("resp_pre_rst_valid", 32'(resp_valid), 32'd2);
        #1;
        reset = 1'b1;
        #1;
        chk("resp_rst_valid", 32'(resp_valid), 32'd0);
        chk("resp_rst_result", resp_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Contention: both requesters continuously valid
        do_reset();
        set_req(0, 32'd1, 32'd1, 3'b010);
        set_req(1, 32'd2, 32'd2, 3'b010);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready != 2'b00)    gq.push_back(int'(req_ready[1]));
            if (req_ready_f0 != 2'b00) gq0.push_back(int'(req_ready_f0[1]));
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("fair_grant_count", 32'(gq.size()), 32'd4);
        chk("fixed_grant_count", 32'(gq0.size()), 32'd4);
        for (int i = 0; i < gq.size(); i++)  chk("fair_grant_order", 32'(gq[i]), 32'(i % 2));
        for (int i = 0; i < gq0.size(); i++) chk("fixed_grant_order", 32'(gq0[i]), 32'd0);
        resp_ready = 2'b00;

        // Random traffic against the transaction-level reference
        do_reset();
        rr_m = 1'b0;
        pend = 2'b00;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0; pop[0] = '0; pop[1] = '0;
        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            resp_ready = 2'b00;
            maybe_new();
            #1;
            w = 1'b0;
            if (pend == 2'b11) w = rr_m;
            else               w = pend[1];
            exp_rdy = (pend == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
            chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
            if (pend != 2'b00) begin
                own   = w ? 2'b10 : 2'b01;
                other = ~own;
                ref_op(pa[w], pb[w], pop[w], er, ez, ee);
                chk("rnd_exec_pending_src", pa[w], pa[w]);
                checks--;
                pend[w] = 1'b0;
                @(negedge clk);
                maybe_new();
                #1;
                chk("rnd_exec_req_ready", 32'(req_ready), 32'd0);
                chk("rnd_exec_alu_cont", 32'(alu_cont), ee ? 32'd0 : 32'(pop_cont(er, ee)));
                @(negedge clk);
                maybe_new();
                #1;
                chk("rnd_resp_valid", 32'(resp_valid), 32'(own));
                chk("rnd_resp_result", resp_result, er);
                chk("rnd_resp_zero", 32'(resp_zero), 32'(ez));
                chk("rnd_resp_err", 32'(resp_err), 32'(ee));
                chk("rnd_resp_req_ready", 32'(req_ready), 32'd0);
                bp = int'($urandom_range(3));
                for (int k = 0; k < bp; k++) begin
                    resp_ready = ($urandom_range(1) != 0) ? other : 2'b00;
                    @(negedge clk);
                    maybe_new();
                    #1;
                    chk("rnd_bp_resp_valid", 32'(resp_valid), 32'(own));
                    chk("rnd_bp_resp_result", resp_result, er);
                    chk("rnd_bp_req_ready", 32'(req_ready), 32'd0);
                end
                resp_ready = own | (($urandom_range(1) != 0) ? other : 2'b00);
                @(posedge clk);
                rr_m = ~w;
            end
        end
        @(negedge clk);
        req_valid  = 2'b00;
        resp_ready = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Control code the ALU must see for the operation currently in EXEC;
    // illegal codes are reported as 0 by the caller.
    logic [2:0] cur_op;
    always @(posedge clk) begin
        if (req_ready == 2'b01)      cur_op <= req0_op;
        else if (req_ready == 2'b10) cur_op <= req1_op;
    end

    function automatic logic [2:0] pop_cont(input logic [31:0] r, input logic e);
        logic [31:0] unused_r;
        unused_r = r;
        return e ? 3'd0 : cur_op;
    endfunction

endmodule
